// File: rtl/i2s_mask_panel.sv
// i2s_mask_panel
//   Locks onto a framed serial stream (sync nibble 4'hA, then a header giving
//   the panel grid size, a blank flag and a row number), then picks out the
//   payload bits that belong to this panel's module coordinates and turns
//   them into LED shift clocks, followed by one latch pulse per frame.
//
// Ports
//   i2s_clk_i     stream bit clock, all state updates on its rising edge
//   rst_i         synchronous active-high reset
//   i2s_data_i    serial stream, MSB first, lane 0 carries the header
//   addr_x_i      this panel's module column
//   addr_y_i      this panel's module row
//   row_num_o     row select, updated at the end of each in-range frame
//   led_data_o    i2s_data_i delayed by one cycle (all lanes)
//   led_clk_en_o  registered shift enable
//   led_clk_o     gated shift clock, rises mid-bit while enabled
//   led_lat_o     one-cycle latch pulse after an in-range frame
//   led_oe_o      output disable (active-high), loaded from the blank flag
//   locked_o      high while a header or payload is being received
module i2s_mask_panel #(
  parameter int MOD_BITS = 4,
  parameter int MOD_ROWS = 4,
  parameter int ADDR_W   = 4,
  parameter int ROW_W    = 6,
  parameter int LANES    = 1,
  parameter int CNT_W    = 16
) (
  input  logic              i2s_clk_i,
  input  logic              rst_i,
  input  logic [LANES-1:0]  i2s_data_i,
  input  logic [ADDR_W-1:0] addr_x_i,
  input  logic [ADDR_W-1:0] addr_y_i,
  output logic [ROW_W-1:0]  row_num_o,
  output logic [LANES-1:0]  led_data_o,
  output logic              led_clk_en_o,
  output logic              led_clk_o,
  output logic              led_lat_o,
  output logic              led_oe_o,
  output logic              locked_o
);

  // Header bits captured after the sync nibble: nx_m1, ny_m1, blank, row.
  localparam int CAP_W = 1 + 2 * ADDR_W + ROW_W;

  localparam logic [CNT_W-1:0] MB_C      = CNT_W'(MOD_BITS);
  localparam logic [CNT_W-1:0] MR_C      = CNT_W'(MOD_ROWS);
  localparam logic [CNT_W-1:0] HDR_LAST_C = CNT_W'(CAP_W - 1);

  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_e;

  state_e             state_q;
  logic [3:0]         shift_q;
  logic [CAP_W-2:0]   hdr_q;
  logic [CNT_W-1:0]   hcnt_q;
  logic [CNT_W-1:0]   p_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   first_q;
  logic [CNT_W-1:0]   stride_q;
  logic [CNT_W-1:0]   pos_q;
  logic [CNT_W-1:0]   win_q;
  logic               inRange_q;
  logic               blank_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   rowNum_q;
  logic [LANES-1:0]   ledData_q;
  logic               clkEn_q;
  logic               lat_q;
  logic               oe_q;

  logic [3:0]         shift_d;
  logic [CAP_W-1:0]   hdr_d;
  logic [ADDR_W-1:0]  hdrNxM1;
  logic [ADDR_W-1:0]  hdrNyM1;
  logic               hdrBlank;
  logic [ROW_W-1:0]   hdrRow;
  logic [CNT_W-1:0]   hdrNx;
  logic [CNT_W-1:0]   hdrNy;
  logic [CNT_W-1:0]   hdrStride;
  logic [CNT_W-1:0]   hdrFirst;
  logic [CNT_W-1:0]   hdrLen;
  logic               hdrInRange;
  logic               pastFirst;
  logic               inWindowRun;
  logic               hit;
  logic               lastBit;

  assign shift_d = {shift_q[2:0], i2s_data_i[0]};
  assign hdr_d   = {hdr_q, i2s_data_i[0]};

  assign hdrNxM1  = hdr_d[CAP_W-1 -: ADDR_W];
  assign hdrNyM1  = hdr_d[CAP_W-1-ADDR_W -: ADDR_W];
  assign hdrBlank = hdr_d[ROW_W];
  assign hdrRow   = hdr_d[ROW_W-1:0];

  // Frame geometry, only meaningful on the last header bit where it is
  // registered. All arithmetic wraps at CNT_W bits.
  assign hdrNx      = CNT_W'(hdrNxM1) + CNT_W'(1);
  assign hdrNy      = CNT_W'(hdrNyM1) + CNT_W'(1);
  assign hdrStride  = hdrNx * MB_C;
  assign hdrFirst   = MB_C * (CNT_W'(addr_y_i) * hdrNx * MR_C + CNT_W'(addr_x_i));
  assign hdrLen     = hdrStride * MR_C * hdrNy;
  assign hdrInRange = (addr_x_i <= hdrNxM1) && (addr_y_i <= hdrNyM1);

  // Rather than test every window with a multiply per bit, pos_q walks one
  // stride at a time from the first window and win_q counts strides done;
  // the first MOD_BITS positions of each stride are this module's bits.
  assign pastFirst   = (p_q >= first_q);
  assign inWindowRun = pastFirst && (win_q < MR_C);
  assign hit         = inWindowRun && (pos_q < MB_C);
  assign lastBit     = (p_q == len_q - CNT_W'(1));

  always_ff @(posedge i2s_clk_i) begin
    if (rst_i) begin
      state_q   <= HUNT;
      shift_q   <= '0;
      hdr_q     <= '0;
      hcnt_q    <= '0;
      p_q       <= '0;
      len_q     <= '0;
      first_q   <= '0;
      stride_q  <= '0;
      pos_q     <= '0;
      win_q     <= '0;
      inRange_q <= 1'b0;
      blank_q   <= 1'b0;
      row_q     <= '0;
      rowNum_q  <= '0;
      ledData_q <= '0;
      clkEn_q   <= 1'b0;
      lat_q     <= 1'b0;
      oe_q      <= 1'b1;
    end else begin
      ledData_q <= i2s_data_i;
      clkEn_q   <= 1'b0;
      lat_q     <= 1'b0;
      case (state_q)
        HUNT: begin
          shift_q <= shift_d;
          if (shift_d == 4'hA) begin
            state_q <= HEADER;
            hcnt_q  <= '0;
          end
        end
        HEADER: begin
          hdr_q  <= hdr_d[CAP_W-2:0];
          hcnt_q <= hcnt_q + CNT_W'(1);
          if (hcnt_q == HDR_LAST_C) begin
            state_q   <= PAYLOAD;
            p_q       <= '0;
            pos_q     <= '0;
            win_q     <= '0;
            len_q     <= hdrLen;
            first_q   <= hdrFirst;
            stride_q  <= hdrStride;
            inRange_q <= hdrInRange;
            blank_q   <= hdrBlank;
            row_q     <= hdrRow;
          end
        end
        PAYLOAD: begin
          p_q     <= p_q + CNT_W'(1);
          clkEn_q <= hit && inRange_q;
          if (inWindowRun) begin
            if (pos_q == stride_q - CNT_W'(1)) begin
              pos_q <= '0;
              win_q <= win_q + CNT_W'(1);
            end else begin
              pos_q <= pos_q + CNT_W'(1);
            end
          end
          // Clearing the shift register lets a back-to-back sync be found
          // starting with the very next bit.
          if (lastBit) begin
            state_q <= HUNT;
            shift_q <= '0;
            if (inRange_q) begin
              lat_q    <= 1'b1;
              rowNum_q <= row_q;
              oe_q     <= blank_q;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign row_num_o    = rowNum_q;
  assign led_data_o   = ledData_q;
  assign led_clk_en_o = clkEn_q;
  assign led_clk_o    = ~i2s_clk_i & clkEn_q;
  assign led_lat_o    = lat_q;
  assign led_oe_o     = oe_q;
  assign locked_o     = (state_q != HUNT);

endmodule

// File: tb/tb_i2s_mask_panel.sv
// tb_i2s_mask_panel
//   Drives framed streams into i2s_mask_panel (two lanes, other parameters
//   at default) and compares every output against a frame-level model:
//   window membership is computed directly from the frame geometry, and
//   latch/row/blank expectations are tracked per completed frame.
module tb_i2s_mask_panel;

  localparam int LANES = 2;

  logic             i2s_clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] i2s_data;
  logic [3:0]       addr_x;
  logic [3:0]       addr_y;
  logic [5:0]       row_num;
  logic [LANES-1:0] led_data;
  logic             led_clk_en;
  logic             led_clk;
  logic             led_lat;
  logic             led_oe;
  logic             locked;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [5:0]       rowExp = 6'd0;
  logic             oeExp  = 1'b1;
  logic [3:0]       hist   = 4'd0;
  logic [LANES-1:0] lastSent;

  always #5 i2s_clk = ~i2s_clk;

  i2s_mask_panel #(
    .MOD_BITS(4), .MOD_ROWS(4), .ADDR_W(4), .ROW_W(6), .LANES(LANES), .CNT_W(16)
  ) dut (
    .i2s_clk_i   (i2s_clk),
    .rst_i       (rst),
    .i2s_data_i  (i2s_data),
    .addr_x_i    (addr_x),
    .addr_y_i    (addr_y),
    .row_num_o   (row_num),
    .led_data_o  (led_data),
    .led_clk_en_o(led_clk_en),
    .led_clk_o   (led_clk),
    .led_lat_o   (led_lat),
    .led_oe_o    (led_oe),
    .locked_o    (locked)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one bit on lane 0 (random on lane 1), clocks it in and checks the
  // one-cycle forwarding of all lanes.
  task automatic applyStimulus(input logic bit0);
    i2s_data = {1'($urandom_range(0, 1)), bit0};
    lastSent = i2s_data;
    @(posedge i2s_clk);
    #1;
    checkOutput("led_data", 32'(led_data), rst ? 32'd0 : 32'(lastSent));
  endtask

  function automatic logic inWindow(input int p, input int first, input int stride);
    for (int k = 0; k < 4; k++) begin
      if (p >= first + k * stride && p <= first + k * stride + 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Unlocked stream: zeros, or random bits that never complete 4'hA.
  task automatic runIdle(input int n, input logic junk);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if ({hist[2:0], b} == 4'hA) b = ~b;
      applyStimulus(b);
      hist = {hist[2:0], b};
      checkOutput("locked_idle", 32'(locked), 32'd0);
      checkOutput("clk_en_idle", 32'(led_clk_en), 32'd0);
      checkOutput("lat_idle", 32'(led_lat), 32'd0);
    end
  endtask

  task automatic runFrame(input logic [3:0] nxM1, input logic [3:0] nyM1,
                          input logic blank, input logic [5:0] row,
                          input logic [3:0] ax, input logic [3:0] ay,
                          input int abortAt);
    logic [18:0] hdr;
    int nx, ny, len, first, stride, enCount;
    logic rangeOk, expEn;
    addr_x = ax;
    addr_y = ay;
    hdr = {4'hA, nxM1, nyM1, blank, row};
    for (int i = 18; i >= 0; i--) begin
      applyStimulus(hdr[i]);
      checkOutput("locked_hdr", 32'(locked), (i <= 15) ? 32'd1 : 32'd0);
      checkOutput("clk_en_hdr", 32'(led_clk_en), 32'd0);
      checkOutput("lat_hdr", 32'(led_lat), 32'd0);
    end
    nx      = int'(nxM1) + 1;
    ny      = int'(nyM1) + 1;
    len     = 16 * nx * ny;
    stride  = 4 * nx;
    first   = 4 * (int'(ay) * nx * 4 + int'(ax));
    rangeOk = (ax <= nxM1) && (ay <= nyM1);
    enCount = 0;
    for (int p = 0; p < len; p++) begin
      if (p == abortAt) begin
        rst = 1'b1;
        applyStimulus(1'($urandom_range(0, 1)));
        rst = 1'b0;
        rowExp = 6'd0;
        oeExp  = 1'b1;
        hist   = 4'd0;
        checkOutput("clk_en_abort", 32'(led_clk_en), 32'd0);
        checkOutput("lat_abort", 32'(led_lat), 32'd0);
        checkOutput("oe_abort", 32'(led_oe), 32'd1);
        checkOutput("row_abort", 32'(row_num), 32'd0);
        checkOutput("locked_abort", 32'(locked), 32'd0);
        return;
      end
      applyStimulus(1'($urandom_range(0, 1)));
      expEn = rangeOk && inWindow(p, first, stride);
      checkOutput("led_clk_en", 32'(led_clk_en), 32'(expEn));
      if (led_clk_en === 1'b1) enCount++;
      checkOutput("locked_pay", 32'(locked), (p != len - 1) ? 32'd1 : 32'd0);
      if (p == len - 1) begin
        if (rangeOk) begin
          rowExp = row;
          oeExp  = blank;
        end
        checkOutput("led_lat_end", 32'(led_lat), 32'(rangeOk));
      end else begin
        checkOutput("led_lat_mid", 32'(led_lat), 32'd0);
      end
      checkOutput("row_num", 32'(row_num), 32'(rowExp));
      checkOutput("led_oe", 32'(led_oe), 32'(oeExp));
      #5;
      checkOutput("led_clk", 32'(led_clk), 32'(expEn));
    end
    checkOutput("pulse_count", 32'(enCount), rangeOk ? 32'd16 : 32'd0);
    hist = 4'd0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired after %0d tests", testsRun);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    i2s_data = '0;
    addr_x   = '0;
    addr_y   = '0;
    repeat (3) @(posedge i2s_clk);
    #1;
    checkOutput("rst_row", 32'(row_num), 32'd0);
    checkOutput("rst_data", 32'(led_data), 32'd0);
    checkOutput("rst_clk_en", 32'(led_clk_en), 32'd0);
    checkOutput("rst_lat", 32'(led_lat), 32'd0);
    checkOutput("rst_oe", 32'(led_oe), 32'd1);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    runIdle(4, 1'b0);

    // Module (1,0) of a 2x2 grid: windows at p 4-7, 12-15, 20-23, 28-31.
    runFrame(4'd1, 4'd1, 1'b0, 6'd5, 4'd1, 4'd0, -1);
    runIdle(5, 1'b0);

    // Module (0,1): windows at p 32-35, 40-43, 48-51, 56-59.
    runFrame(4'd1, 4'd1, 1'b0, 6'd5, 4'd0, 4'd1, -1);
    runIdle(5, 1'b0);

    // Column 3 is outside a two-column grid: no pulses, row/oe untouched.
    runFrame(4'd1, 4'd1, 1'b1, 6'd7, 4'd3, 4'd0, -1);
    runIdle(5, 1'b0);

    // Junk without a sync pattern, then a random frame.
    runIdle(40, 1'b1);
    runIdle(3, 1'b0);
    runFrame(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), -1);

    // Back-to-back frames with no gap.
    runFrame(4'd1, 4'd1, 1'b0, 6'd5, 4'd1, 4'd1, -1);
    runFrame(4'd1, 4'd1, 1'b1, 6'd9, 4'd1, 4'd1, -1);
    runIdle(5, 1'b0);

    // Reset in the middle of the payload, then a normal frame.
    runFrame(4'd1, 4'd1, 1'b0, 6'd5, 4'd1, 4'd0, 10);
    runIdle(20, 1'b0);
    runFrame(4'd1, 4'd1, 1'b0, 6'd12, 4'd1, 4'd0, -1);
    runIdle(5, 1'b0);

    // A few random geometries, occasionally out of range.
    for (int n = 0; n < 4; n++) begin
      runIdle(8, 1'b1);
      runIdle(3, 1'b0);
      runFrame(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
               4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), -1);
    end
    runIdle(4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
